// File: rtl/systolic_pkg.sv
// ---------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic array operand feeder.
//   state_t      : feeder sequencing states (IDLE, FEED, HOLD)
//   DEF_BITWIDTH : default operand width in bits
//   DEF_N        : default array dimension (N x N)
//   FEED_CYCLES  : number of FEED cycles for the default dimension (3N-2)
//   feedCycles() : FEED length for an arbitrary dimension
// ---------------------------------------------------------------------------
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FEED = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int DEF_BITWIDTH = 4;
    localparam int DEF_N        = 4;

    // The last operand enters PE(N-1,N-1) at t = 3N-3, so FEED lasts 3N-2 cycles.
    function automatic int feedCycles(input int n);
        return 3 * n - 2;
    endfunction

    localparam int FEED_CYCLES = 3 * DEF_N - 2;

endpackage

// File: rtl/systolic_feeder.sv
// ---------------------------------------------------------------------------
// systolic_feeder
// Captures an N x N matrix pair on request and streams it, skewed, into the
// west and north edges of an output-stationary systolic array, then holds the
// array until the consumer acknowledges the result.
// Ports:
//   i_clk        : clock, all state changes on the rising edge
//   i_arst       : synchronous active-high reset
//   i_start      : request to load and stream a matrix pair (taken in IDLE)
//   o_ready      : high only in IDLE
//   i_matA       : matrix A, row-major, A[i][k] at element index i*N+k
//   i_matB       : matrix B, row-major, B[k][j] at element index k*N+j
//   o_rowA       : west-edge operand for array row i in slice i
//   o_colB       : north-edge operand for array column j in slice j
//   o_doProcess  : PE enable; low clears the PE accumulators
//   o_resValid   : accumulators hold the complete product A*B
//   i_resAck     : consumer has read the result (taken in HOLD)
// ---------------------------------------------------------------------------
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int BITWIDTH = DEF_BITWIDTH,
    parameter int N        = DEF_N
) (
    input  logic                      i_clk,
    input  logic                      i_arst,
    input  logic                      i_start,
    output logic                      o_ready,
    input  logic [N*N*BITWIDTH-1:0]   i_matA,
    input  logic [N*N*BITWIDTH-1:0]   i_matB,
    output logic [N*BITWIDTH-1:0]     o_rowA,
    output logic [N*BITWIDTH-1:0]     o_colB,
    output logic                      o_doProcess,
    output logic                      o_resValid,
    input  logic                      i_resAck
);

    localparam int CW     = $clog2(3 * N - 1);
    localparam int LAST_T = feedCycles(N) - 1;

    state_t                    r_state;
    logic [CW-1:0]             r_cnt;
    logic [N*N*BITWIDTH-1:0]   r_matA;
    logic [N*N*BITWIDTH-1:0]   r_matB;
    logic                      r_ready;
    logic                      r_doProcess;
    logic                      r_resValid;

    state_t                    w_nextState;
    logic [CW-1:0]             w_nextCnt;
    logic                      w_accept;
    logic [N*N*BITWIDTH-1:0]   w_srcA;
    logic [N*N*BITWIDTH-1:0]   w_srcB;

    // Next state and next cycle index. Every output is registered, so the
    // edge values for cycle t are computed one cycle early from (next state,
    // next count); the counter therefore restarts at 0 on the accept edge.
    always_comb begin
        w_accept    = (r_state == IDLE) && i_start;
        w_nextState = r_state;
        w_nextCnt   = '0;
        case (r_state)
            IDLE: if (i_start) w_nextState = FEED;
            FEED: begin
                if (r_cnt == CW'(LAST_T)) w_nextState = HOLD;
                else                      w_nextCnt   = r_cnt + 1'b1;
            end
            HOLD: if (i_resAck) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // On the accept edge the stored matrices are not yet loaded, so the t=0
    // operands must come straight from the input ports.
    assign w_srcA = w_accept ? i_matA : r_matA;
    assign w_srcB = w_accept ? i_matB : r_matB;

    // Sequencer state, operand storage and the state-derived flags.
    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_matA      <= '0;
            r_matB      <= '0;
            r_ready     <= 1'b1;
            r_doProcess <= 1'b0;
            r_resValid  <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_cnt       <= w_nextCnt;
            if (w_accept) begin
                r_matA <= i_matA;
                r_matB <= i_matB;
            end
            r_ready     <= (w_nextState == IDLE);
            r_doProcess <= (w_nextState != IDLE);
            r_resValid  <= (w_nextState == HOLD);
        end
    end

    assign o_ready     = r_ready;
    assign o_doProcess = r_doProcess;
    assign o_resValid  = r_resValid;

    // West edge: row i is delayed by i cycles, so in cycle t it carries
    // A[i][t-i], and zero outside the window.
    for (genvar gi = 0; gi < N; gi++) begin : g_row
        logic [BITWIDTH-1:0] w_next;
        logic [BITWIDTH-1:0] r_val;

        always_comb begin
            w_next = '0;
            if (w_nextState == FEED) begin
                for (int k = 0; k < N; k++) begin
                    if (int'(w_nextCnt) == gi + k)
                        w_next = w_srcA[(gi*N + k)*BITWIDTH +: BITWIDTH];
                end
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_arst) r_val <= '0;
            else        r_val <= w_next;
        end

        assign o_rowA[gi*BITWIDTH +: BITWIDTH] = r_val;
    end

    // North edge: column j is delayed by j cycles, carrying B[t-j][j].
    for (genvar gj = 0; gj < N; gj++) begin : g_col
        logic [BITWIDTH-1:0] w_next;
        logic [BITWIDTH-1:0] r_val;

        always_comb begin
            w_next = '0;
            if (w_nextState == FEED) begin
                for (int k = 0; k < N; k++) begin
                    if (int'(w_nextCnt) == gj + k)
                        w_next = w_srcB[(k*N + gj)*BITWIDTH +: BITWIDTH];
                end
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_arst) r_val <= '0;
            else        r_val <= w_next;
        end

        assign o_colB[gj*BITWIDTH +: BITWIDTH] = r_val;
    end

endmodule
